// File: rtl/vtg_mux_pkg.sv
// rtl/vtg_mux_pkg.sv - shared types, defaults and width helper for the vtg_mux select sequencer
package vtg_mux_pkg;

    // Default timing in clock cycles
    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_DWELL_CYC  = 4;
    localparam int DEF_PERIOD_CYC = 16;

    // Sequencer phase: waiting for a request, letting the mux output settle,
    // then holding the new select for a minimum dwell
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Width that can hold the largest of the three cycle counts
    function automatic int cnt_width(input int settle_cyc, input int dwell_cyc, input int period_cyc);
        int m;
        m = settle_cyc;
        if (dwell_cyc > m) begin
            m = dwell_cyc;
        end
        if (period_cyc > m) begin
            m = period_cyc;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vtg_down_counter.sv
// rtl/vtg_down_counter.sv - loadable down counter that stops at zero
module vtg_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vtg_mux_sel_ctrl.sv
// rtl/vtg_mux_sel_ctrl.sv - select-line sequencer with settle/dwell guard and periodic auto-toggle
module vtg_mux_sel_ctrl
    import vtg_mux_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int DWELL_CYC  = DEF_DWELL_CYC,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic target,
    input  logic auto_en,
    output logic sel,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(SETTLE_CYC, DWELL_CYC, PERIOD_CYC);

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DWELL_LD  = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LD = CW'(PERIOD_CYC - 1);

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] idle_q, idle_d;

    logic          ph_load;
    logic [CW-1:0] ph_load_val;
    logic          ph_en;
    logic          ph_zero;

    // One counter serves both settle and dwell: reloaded at each phase entry
    vtg_down_counter #(
        .W (CW)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_load_val),
        .en       (ph_en),
        .zero     (ph_zero)
    );

    assign ph_en = (state_q != ST_IDLE);

    // Next-state logic; an explicit request always pre-empts an auto expiry
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idle_d      = '0;
        ph_load     = 1'b0;
        ph_load_val = SETTLE_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (target != sel_q) begin
                        sel_d   = target;
                        busy_d  = 1'b1;
                        state_d = ST_SETTLE;
                        ph_load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (auto_en) begin
                    if (idle_q == PERIOD_LD) begin
                        sel_d   = ~sel_q;
                        busy_d  = 1'b1;
                        state_d = ST_SETTLE;
                        ph_load = 1'b1;
                    end else begin
                        idle_d = idle_q + CW'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (ph_zero) begin
                    state_d     = ST_HOLD;
                    done_d      = 1'b1;
                    ph_load     = 1'b1;
                    ph_load_val = DWELL_LD;
                end
            end
            ST_HOLD: begin
                if (ph_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any request without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_vtg_mux_sel_ctrl.sv
// tb/tb_vtg_mux_sel_ctrl.sv - directed self-checking bench for vtg_mux_sel_ctrl
module tb_vtg_mux_sel_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req;
    logic target;
    logic auto_en;
    logic sel;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    vtg_mux_sel_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .target  (target),
        .auto_en (auto_en),
        .sel     (sel),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int nchg;
        int bad;
        int first_chg;
        int second_chg;
        logic prev;

        rst = 1'b1; req = 1'b0; target = 1'b0; auto_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_sel", sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        // Accepted request: sel after 1 edge, done 2 edges later, busy 6 cycles
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            req    = (i == 0);
            target = (i == 0);
            tick();
            if (i == 0) begin
                chk("accept_sel", sel, 1);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
        end
        chk("accept_busy_cycles", busy_cnt, 6);
        chk("accept_done_count", done_cnt, 1);
        chk("accept_done_at", done_at, 2);
        chk("accept_idle_after", busy, 0);

        // Same-target request: done only, then immediate accept on the next edge
        req = 1'b1; target = 1'b1;
        tick();
        chk("same_done", done, 1);
        chk("same_busy", busy, 0);
        chk("same_sel", sel, 1);
        req = 1'b1; target = 1'b0;
        tick();
        chk("reaccept_sel", sel, 0);
        chk("reaccept_busy", busy, 1);
        chk("reaccept_done", done, 0);
        req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("reaccept_idle", busy, 0);

        // Held request with alternating target: toggles every 7 cycles
        prev = sel; nchg = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            req    = 1'b1;
            target = ((i % 2) == 0);
            tick();
            if (sel !== prev) begin
                if ((i % 7) != 0) bad++;
                nchg++;
                prev = sel;
            end
        end
        chk("alt_toggles", nchg, 5);
        chk("alt_spacing", bad, 0);
        chk("alt_sel_final", sel, 1);
        req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("alt_idle", busy, 0);

        // Auto-toggle: first at the 16th edge, then every 22 cycles
        auto_en = 1'b1;
        prev = sel; nchg = 0; first_chg = -1; second_chg = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sel !== prev) begin
                if (nchg == 0) first_chg = i;
                if (nchg == 1) second_chg = i;
                nchg++;
                prev = sel;
            end
        end
        chk("auto_count", nchg, 2);
        chk("auto_first", first_chg, 15);
        chk("auto_second", second_chg, 37);

        // Disable mid-count, then re-enable: period restarts from zero
        auto_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("auto_off_sel", sel, 1);
        auto_en = 1'b1;
        prev = sel; nchg = 0; first_chg = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sel !== prev) begin
                if (nchg == 0) first_chg = i;
                nchg++;
                prev = sel;
            end
        end
        chk("auto_restart_count", nchg, 1);
        chk("auto_restart_at", first_chg, 15);
        auto_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("auto_restart_idle", busy, 0);

        // Request with target==sel on the auto-expiry edge: done only, counter restarts
        auto_en = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("coll_pre_sel", sel, 0);
        req = 1'b1; target = 1'b0;
        tick();
        chk("coll_done", done, 1);
        chk("coll_sel", sel, 0);
        chk("coll_busy", busy, 0);
        req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("coll_wait_sel", sel, 0);
        tick();
        chk("coll_toggle_sel", sel, 1);
        chk("coll_toggle_busy", busy, 1);
        auto_en = 1'b0;

        // Reset during HOLD: everything back to reset values, then a fresh accept
        for (int i = 0; i < 3; i++) tick();
        chk("hold_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("rst_hold_sel", sel, 0);
        chk("rst_hold_busy", busy, 0);
        chk("rst_hold_done", done, 0);
        rst = 1'b0; req = 1'b1; target = 1'b1;
        tick();
        chk("post_rst_sel", sel, 1);
        chk("post_rst_busy", busy, 1);
        req = 1'b0;
        tick();
        chk("post_rst_nodone", done, 0);
        tick();
        chk("post_rst_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vtg_mux_sel_ctrl.md
# vtg_mux_sel_ctrl

Select-line sequencer that drives the `sel` input of the `vtg_mux` 2:1 multiplexer. It accepts explicit switch requests through a req/busy handshake and can also auto-toggle periodically. After each switch it enforces a settle interval, then a minimum dwell, so downstream logic sees clean and bounded select changes. It sits directly upstream of `vtg_mux`, and its `sel` output is wired straight to the mux `sel` port.

## Interface
- `SETTLE_CYC`, default 2: cycles from a `sel` change to the `done` pulse; legal range ≥1.
- `DWELL_CYC`, default 4: cycles `sel` is held after `done` before a new request is accepted; legal range ≥1.
- `PERIOD_CYC`, default 16: idle cycles before an automatic toggle while `auto_en`=1; legal range ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 1: switch request; sampled only on edges where `busy`=0.
- `target` in 1: requested `sel` value, qualified by `req`.
- `auto_en` in 1: enables periodic auto-toggle while idle.
- `sel` out 1: registered select driving `vtg_mux.sel`.
- `busy` out 1: high while settling or dwelling; requests are ignored while high.
- `done` out 1: one-cycle pulse marking request completion.

## Operation
- States:
  - IDLE: `busy`=0.
  - SETTLE: `busy`=1.
  - HOLD: `busy`=1.
- Reset values: `sel`=0, `busy`=0, `done`=0, state IDLE, all counters 0. `rst` dominates every other input.
- IDLE, `req`=1, `target`≠`sel` (accept):
  - next edge: `sel`←`target`, `busy`←1, state SETTLE, counter←SETTLE_CYC−1.
- IDLE, `req`=1, `target`=`sel`:
  - next edge: `done`←1 for one cycle; `sel` and `busy` unchanged; state remains IDLE.
- SETTLE:
  - counter decrements each edge.
  - On the edge where counter=0: state HOLD, `done`←1 (one cycle), counter←DWELL_CYC−1.
- HOLD:
  - counter decrements each edge.
  - On the edge where counter=0: state IDLE, `busy`←0.
- `req` while `busy`=1: ignored entirely; it is not queued.
- Auto-toggle:
  - In IDLE with `auto_en`=1 and `req`=0, the idle counter increments each edge.
  - When it equals PERIOD_CYC−1, the block behaves as an accepted request with `target`=~`sel`, and the idle counter clears.
  - The idle counter clears whenever `auto_en`=0, state≠IDLE, or `req`=1.
- Simultaneous `req` and auto-expiry on the same edge: the explicit `req` wins and the auto event is discarded.
- `target` changes while busy have no effect.
- Reset mid-SETTLE or mid-HOLD: at the next edge, all outputs and state return to reset values. No `done` pulse is emitted for the aborted request.

## Timing
- `req` accepted at edge T → `sel` changes after edge T (1-cycle latency).
- `done` is high for exactly one cycle, after edge T+SETTLE_CYC.
- `busy` is high from after edge T through edge T+SETTLE_CYC+DWELL_CYC, then low.
- Earliest next acceptance: edge T+SETTLE_CYC+DWELL_CYC+1 when `req` is held high. A new accept therefore occurs at most every SETTLE_CYC+DWELL_CYC+1 cycles.
- Auto mode with constant `auto_en`: toggle period = PERIOD_CYC + SETTLE_CYC + DWELL_CYC cycles.
- Same-target `req` at edge T: `done` is high after edge T; the block can accept again at edge T+1.
- Counter widths are $clog2(max(SETTLE_CYC, DWELL_CYC, PERIOD_CYC)+1) bits. Counters never wrap; they are reloaded or cleared on every state change.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `vtg_mux_pkg` holds:
  - the state typedef (IDLE/SETTLE/HOLD, 2-bit encoding);
  - a counter-width helper function;
  - default parameter constants.
- Sub-module `vtg_down_counter`, reused for the settle and dwell phases, with ports:
  - `clk`, `rst`, `load`, `load_val`, `en`, `zero`.
- The idle/period counter is inline, kept separate because it counts up and uses a distinct clear condition.

## Test plan
- Reset, then `req`=1 with `target`=1 for one cycle (defaults):
  - `sel`=1 one cycle later;
  - `done` pulses 2 cycles after the `sel` change;
  - `busy` is high for 6 cycles total.
- `req` with `target`=1 while `sel`=1:
  - single `done` pulse next cycle;
  - `busy` stays 0;
  - `sel` unchanged.
- `req` held high with `target` alternating each cycle:
  - `sel` toggles exactly every 7 cycles;
  - all requests made while `busy`=1 are dropped.
- `auto_en`=1, `req`=0, PERIOD_CYC=16:
  - `sel` toggles every 22 cycles;
  - `auto_en`=0 mid-count halts toggling and restarts the period on re-enable.
- `req` and auto-expiry on the same edge with `target`=`sel`:
  - `done` pulse only, no toggle;
  - idle counter restarts from 0.
- `rst` asserted during HOLD:
  - next cycle `sel`=0, `busy`=0, `done`=0;
  - a `req` issued immediately after reset release is accepted.
